// File: rtl/axi_burst_master.sv
// AXI burst master: cache-refill reads for inst/data clients plus a single-beat data write path.
// Build option: AXI_CRITICAL_WORD_FIRST_EN selects WRAP bursts that return the requested word first.
module axi_burst_master #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  localparam int unsigned IDX_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              flush,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_rvalid,
  output logic              inst_rlast,
  output logic [IDX_W-1:0]  inst_rindex,
  input  logic              data_rreq,
  input  logic [ADDR_W-1:0] data_raddr,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_rvalid,
  output logic              data_rlast,
  output logic [IDX_W-1:0]  data_rindex,
  input  logic              data_wreq,
  input  logic [ADDR_W-1:0] data_waddr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [3:0]        data_wstrb,
  output logic              data_bvalid,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [3:0]        wid,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [3:0]        bid,
  input  logic              bvalid,
  output logic              bready
);

`ifdef AXI_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = (LINE_WORDS > 1);
`else
  localparam bit CWF = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(3);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;

  rstate_t          rstate;
  wstate_t          wstate;
  logic             rclient;
  logic             drop;
  logic [IDX_W-1:0] ridx;

  logic              grant_data, grant_inst, data_read_busy;
  logic [ADDR_W-1:0] req_addr;
  logic              beat, aw_done, w_done;

  // Data read wins ties; it waits for the write path to drain (RAW ordering).
  assign grant_data     = (rstate == R_IDLE) && data_rreq && (wstate == W_IDLE);
  assign grant_inst     = (rstate == R_IDLE) && !grant_data && inst_req;
  assign data_read_busy = ((rstate != R_IDLE) && rclient) || grant_data;
  assign req_addr       = grant_data ? data_raddr : inst_addr;

  assign beat        = (rstate == R_DATA) && rvalid;
  assign inst_rdata  = rdata;
  assign data_rdata  = rdata;
  assign inst_rvalid = beat && !rclient && !drop && !flush;
  assign inst_rlast  = inst_rvalid && rlast;
  assign data_rvalid = beat && rclient;
  assign data_rlast  = data_rvalid && rlast;
  assign inst_rindex = ridx;
  assign data_rindex = ridx;

  assign aw_done     = !awvalid || awready;
  assign w_done      = !wvalid || wready;
  assign data_bvalid = bready && bvalid;

  // Single outstanding read, so response IDs carry no information.
  logic unused_ids;
  assign unused_ids = ^{rid, bid};

  // Read FSM
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rstate  <= R_IDLE;
      rclient <= 1'b0;
      drop    <= 1'b0;
      ridx    <= '0;
      arvalid <= 1'b0;
      arid    <= '0;
      araddr  <= '0;
      arlen   <= '0;
      arsize  <= '0;
      arburst <= '0;
      rready  <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (grant_data || grant_inst) begin
            rclient <= grant_data;
            arid    <= {3'b000, grant_data};
            araddr  <= CWF ? (req_addr & ~WORD_MASK) : (req_addr & ~LINE_MASK);
            arlen   <= 4'(LINE_WORDS - 1);
            arsize  <= 3'b010;
            arburst <= CWF ? 2'b10 : 2'b01;
            ridx    <= CWF ? IDX_W'(req_addr >> 2) : '0;
            drop    <= 1'b0;
            arvalid <= 1'b1;
            rstate  <= R_AR;
          end
        end
        R_AR: begin
          if (flush && !rclient) drop <= 1'b1;
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (flush && !rclient) drop <= 1'b1;
          if (rvalid) begin
            if (LINE_WORDS > 1) ridx <= ridx + IDX_W'(1);
            if (rlast) begin
              rready <= 1'b0;
              drop   <= 1'b0;
              rstate <= R_IDLE;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Write FSM: one beat, AW and W raised together, each dropped on its own handshake
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wstate  <= W_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      wlast   <= 1'b0;
      bready  <= 1'b0;
      awid    <= '0;
      awaddr  <= '0;
      awlen   <= '0;
      awsize  <= '0;
      awburst <= '0;
      wid     <= '0;
      wdata   <= '0;
      wstrb   <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (data_wreq && !data_read_busy) begin
            awaddr  <= data_waddr;
            wdata   <= data_wdata;
            wstrb   <= data_wstrb;
            awid    <= 4'd1;
            wid     <= 4'd1;
            awlen   <= 4'd0;
            awsize  <= 3'b010;
            awburst <= 2'b01;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            wlast   <= 1'b1;
            wstate  <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (awready) awvalid <= 1'b0;
          if (wready) begin
            wvalid <= 1'b0;
            wlast  <= 1'b0;
          end
          if (aw_done && w_done) begin
            bready <= 1'b1;
            wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            wstate <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master; expectations follow AXI_CRITICAL_WORD_FIRST_EN if defined.
module tb_axi_burst_master;

`ifdef AXI_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  localparam logic [1:0]  EXP_BURST = CWF ? 2'b10 : 2'b01;
  localparam logic [31:0] BOOT_ADDR = 32'hBFC0_0014;
  localparam logic [31:0] BOOT_AR   = CWF ? 32'hBFC0_0014 : 32'hBFC0_0000;
  localparam logic [2:0]  BOOT_IDX  = CWF ? 3'd5 : 3'd0;
  localparam logic [31:0] DATA_ADDR = 32'h0000_1008;
  localparam logic [31:0] DATA_AR   = CWF ? 32'h0000_1008 : 32'h0000_1000;
  localparam logic [2:0]  DATA_IDX  = CWF ? 3'd2 : 3'd0;

  logic        aclk = 1'b0;
  logic        aresetn, flush, inst_req, data_rreq, data_wreq;
  logic [31:0] inst_addr, data_raddr, data_waddr, data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_rvalid, inst_rlast, data_rvalid, data_rlast, data_bvalid;
  logic [2:0]  inst_rindex, data_rindex;
  logic [3:0]  arid, arlen, awid, awlen, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int compared   = 0;
  int mismatched = 0;

  always #5 aclk = ~aclk;

  axi_burst_master #(.LINE_WORDS(8), .ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_rvalid(inst_rvalid), .inst_rlast(inst_rlast), .inst_rindex(inst_rindex),
    .data_rreq(data_rreq), .data_raddr(data_raddr), .data_rdata(data_rdata),
    .data_rvalid(data_rvalid), .data_rlast(data_rlast), .data_rindex(data_rindex),
    .data_wreq(data_wreq), .data_waddr(data_waddr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_bvalid(data_bvalid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Acts as the AXI read slave for one 8-beat burst; flush_at < 0 means no flush.
  task automatic serve(input logic client, input logic [31:0] exp_ar, input logic [2:0] start,
                       input int flush_at);
    int   n = 0;
    logic deliver;
    logic [2:0] ei;
    while (!arvalid && n < 20) begin step(); n++; end
    chk("ar_wait", 64'(arvalid), 64'd1);
    chk("arid", 64'(arid), 64'(client));
    chk("araddr", 64'(araddr), 64'(exp_ar));
    chk("arlen", 64'(arlen), 64'd7);
    chk("arsize", 64'(arsize), 64'd2);
    chk("arburst", 64'(arburst), 64'(EXP_BURST));
    arready = 1'b1;
    step();
    arready = 1'b0;
    #1;
    chk("rready_start", 64'(rready), 64'd1);
    for (int b = 0; b < 8; b++) begin
      if (b == flush_at) begin
        rvalid = 1'b0;
        flush  = 1'b1;
        #1;
        chk("flush_gap_valid", 64'(inst_rvalid), 64'd0);
        step();
        flush = 1'b0;
      end
      deliver = !(flush_at >= 0 && b >= flush_at);
      ei      = start + 3'(b);
      rvalid  = 1'b1;
      rdata   = 32'hA5A5_0000 + 32'(b);
      rlast   = (b == 7);
      #1;
      chk("rready_beat", 64'(rready), 64'd1);
      if (client) begin
        chk("data_rvalid", 64'(data_rvalid), 64'd1);
        chk("data_rlast", 64'(data_rlast), 64'(b == 7));
        chk("data_rindex", 64'(data_rindex), 64'(ei));
        chk("data_rdata", 64'(data_rdata), 64'(32'hA5A5_0000 + 32'(b)));
        chk("inst_quiet", 64'(inst_rvalid), 64'd0);
      end else begin
        chk("inst_rvalid", 64'(inst_rvalid), 64'(deliver));
        chk("inst_rlast", 64'(inst_rlast), 64'(deliver && b == 7));
        chk("data_quiet", 64'(data_rvalid), 64'd0);
        if (deliver) begin
          chk("inst_rindex", 64'(inst_rindex), 64'(ei));
          chk("inst_rdata", 64'(inst_rdata), 64'(32'hA5A5_0000 + 32'(b)));
        end
      end
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    if (client) data_rreq = 1'b0;
    else inst_req = 1'b0;
    #1;
    chk("rready_end", 64'(rready), 64'd0);
  endtask

  initial begin
    aresetn = 1'b0; flush = 1'b0; inst_req = 1'b0; data_rreq = 1'b0; data_wreq = 1'b0;
    inst_addr = '0; data_raddr = '0; data_waddr = '0; data_wdata = '0; data_wstrb = '0;
    arready = 1'b0; rid = '0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bvalid = 1'b0;
    step(); step();
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid", 64'(wvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_bready", 64'(bready), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    aresetn = 1'b1;
    step();

    // Inst refill; arvalid one cycle after request
    inst_req = 1'b1; inst_addr = BOOT_ADDR;
    #1;
    chk("lat_arvalid_low", 64'(arvalid), 64'd0);
    step();
    chk("lat_arvalid_high", 64'(arvalid), 64'd1);
    serve(1'b0, BOOT_AR, BOOT_IDX, -1);

    // Simultaneous requests: data first, then inst
    inst_req = 1'b1; inst_addr = BOOT_ADDR;
    data_rreq = 1'b1; data_raddr = DATA_ADDR;
    step();
    serve(1'b1, DATA_AR, DATA_IDX, -1);
    serve(1'b0, BOOT_AR, BOOT_IDX, -1);

    // Write with delayed awready; pending data read waits for W_IDLE
    data_wreq = 1'b1; data_waddr = 32'h1FAF_F000; data_wdata = 32'h1234_5678; data_wstrb = 4'b0011;
    step();
    chk("awvalid", 64'(awvalid), 64'd1);
    chk("wvalid", 64'(wvalid), 64'd1);
    chk("awaddr", 64'(awaddr), 64'h1FAF_F000);
    chk("wdata", 64'(wdata), 64'h1234_5678);
    chk("wstrb", 64'(wstrb), 64'h3);
    chk("wlast", 64'(wlast), 64'd1);
    chk("awid_wid", 64'({awid, wid}), 64'h11);
    chk("aw_len_size_burst", 64'({awlen, awsize, awburst}), 64'({4'd0, 3'd2, 2'b01}));
    wready = 1'b1; data_rreq = 1'b1; data_raddr = 32'h0000_2000;
    step();
    wready = 1'b0;
    chk("wvalid_dropped", 64'(wvalid), 64'd0);
    chk("awvalid_held", 64'(awvalid), 64'd1);
    step(); step();
    chk("aw_still_waiting", 64'(awvalid), 64'd1);
    chk("read_blocked_aw", 64'(arvalid), 64'd0);
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("awvalid_dropped", 64'(awvalid), 64'd0);
    chk("bready", 64'(bready), 64'd1);
    chk("read_blocked_b", 64'(arvalid), 64'd0);
    bvalid = 1'b1;
    #1;
    chk("data_bvalid", 64'(data_bvalid), 64'd1);
    step();
    bvalid = 1'b0; data_wreq = 1'b0;
    #1;
    chk("data_bvalid_pulse", 64'(data_bvalid), 64'd0);
    chk("bready_low", 64'(bready), 64'd0);
    serve(1'b1, 32'h0000_2000, 3'd0, -1);

    // Flush after beat 2 of an inst burst, then a normal refill
    inst_req = 1'b1; inst_addr = 32'h0000_0040;
    step();
    serve(1'b0, 32'h0000_0040, 3'd0, 2);
    inst_req = 1'b1; inst_addr = BOOT_ADDR;
    step();
    serve(1'b0, BOOT_AR, BOOT_IDX, -1);

    // Reset during beat 4
    inst_req = 1'b1; inst_addr = 32'h0000_0080;
    step();
    chk("rst_burst_ar", 64'(arvalid), 64'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      rvalid = 1'b1; rdata = 32'(b); rlast = 1'b0;
      step();
    end
    aresetn = 1'b0;
    step();
    rvalid = 1'b0; inst_req = 1'b0;
    #1;
    chk("midrst_arvalid", 64'(arvalid), 64'd0);
    chk("midrst_rready", 64'(rready), 64'd0);
    chk("midrst_inst_rvalid", 64'(inst_rvalid), 64'd0);
    chk("midrst_fields", 64'({araddr, arid, arlen, arburst}), 64'd0);
    chk("midrst_wpath", 64'({awvalid, wvalid, wlast, bready}), 64'd0);
    aresetn = 1'b1;
    step();
    inst_req = 1'b1; inst_addr = BOOT_ADDR;
    step();
    serve(1'b0, BOOT_AR, BOOT_IDX, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
